// File: rtl/enc_pkg.sv
// Shared widths, FSM state encoding and the bit-reverse helper for the
// encryption-core request scheduler.
package enc_pkg;

  localparam int PLAIN_W = 128;
  localparam int KEY_W   = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Converts the core's ascending bit ordering to descending.
  function automatic logic [PLAIN_W-1:0] bit_rev(input logic [PLAIN_W-1:0] d);
    logic [PLAIN_W-1:0] r;
    for (int k = 0; k < PLAIN_W; k++) begin
      r[PLAIN_W-1-k] = d[k];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; ptr=0 favours requester 0 on a tie.
// A lone valid requester is always granted, whatever the pointer says.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  assign grant[0] = valid[0] & (~valid[1] | ~ptr);
  assign grant[1] = valid[1] & (~valid[0] |  ptr);

endmodule

// File: rtl/enc_req_sched.sv
// Two-requester scheduler/sequencer for the 128-bit block / 64-bit key core.
// Optional macro ENC_REQ_SCHED_BITREV_EN: bit-reverse the captured cipher.
module enc_req_sched
  import enc_pkg::*;
#(
  parameter int CORE_LAT = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [PLAIN_W-1:0] req0_plain,
  input  logic [KEY_W-1:0]   req0_key,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [PLAIN_W-1:0] req1_plain,
  input  logic [KEY_W-1:0]   req1_key,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [PLAIN_W-1:0] rsp_cipher,
  output logic               rsp_id,
  output logic [PLAIN_W-1:0] core_plain,
  output logic [KEY_W-1:0]   core_key,
  input  logic [PLAIN_W-1:0] core_cipher,
  output logic               busy
);

  state_t             state, state_nxt;
  logic [7:0]         cnt;
  logic               ptr;
  logic [1:0]         grant;
  logic               req_hs;
  logic               lat_done;
  logic               rsp_hs;
  logic [PLAIN_W-1:0] cipher_cap;

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req0_ready = (state == IDLE) && grant[0];
  assign req1_ready = (state == IDLE) && grant[1];
  assign req_hs     = req0_ready | req1_ready;
  // Counter reads k-1 just before edge E0+k, so the capture edge is E0+CORE_LAT.
  assign lat_done   = (state == WAIT) && (cnt == 8'(CORE_LAT - 1));
  assign rsp_hs     = rsp_valid && rsp_ready;
  assign busy       = (state != IDLE);

`ifdef ENC_REQ_SCHED_BITREV_EN
  assign cipher_cap = bit_rev(core_cipher);
`else
  assign cipher_cap = core_cipher;
`endif

  // NOTE: next-state takes its default first so every path assigns it and
  // no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_hs)    state_nxt = WAIT;
      WAIT:    if (lat_done)  state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt        <= '0;
      ptr        <= 1'b0;
      core_plain <= '0;
      core_key   <= '0;
      rsp_id     <= 1'b0;
      rsp_cipher <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      if (req_hs) begin
        core_plain <= grant[1] ? req1_plain : req0_plain;
        core_key   <= grant[1] ? req1_key   : req0_key;
        rsp_id     <= grant[1];
        cnt        <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
      if (lat_done) begin
        rsp_cipher <= cipher_cap;
        rsp_valid  <= 1'b1;
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        ptr       <= ~rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_enc_req_sched.sv
// Directed bench for enc_req_sched with a 4-cycle stub core (cipher = ~plain).
module tb_enc_req_sched;
  import enc_pkg::*;

  localparam int CORE_LAT = 4;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic               req0_valid = 1'b0, req1_valid = 1'b0;
  logic               req0_ready, req1_ready;
  logic [PLAIN_W-1:0] req0_plain = '0, req1_plain = '0;
  logic [KEY_W-1:0]   req0_key = '0, req1_key = '0;
  logic               rsp_valid, rsp_id, busy;
  logic               rsp_ready = 1'b0;
  logic [PLAIN_W-1:0] rsp_cipher, core_plain, core_cipher;
  logic [KEY_W-1:0]   core_key;
  logic [PLAIN_W-1:0] s1 = '0, s2 = '0, s3 = '0;

  int total = 0;
  int bad = 0;

  enc_req_sched #(.CORE_LAT(CORE_LAT)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_plain  (req0_plain),
    .req0_key    (req0_key),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_plain  (req1_plain),
    .req1_key    (req1_key),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_cipher  (rsp_cipher),
    .rsp_id      (rsp_id),
    .core_plain  (core_plain),
    .core_key    (core_key),
    .core_cipher (core_cipher),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Stub core: ~core_plain appears three edges after the input changes,
  // so it is valid at the scheduler's capture edge and not one edge sooner.
  always @(posedge sys_clk) begin
    s1 <= ~core_plain;
    s2 <= s1;
    s3 <= s2;
  end
  assign core_cipher = s3;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    check("rsp_timeout", 128'(rsp_valid), 128'(1'b1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"},  128'(rsp_valid),  '0);
    check({tag, "_busy"},       128'(busy),       '0);
    check({tag, "_core_plain"}, core_plain,       '0);
    check({tag, "_core_key"},   128'(core_key),   '0);
    check({tag, "_rsp_cipher"}, rsp_cipher,       '0);
    check({tag, "_rsp_id"},     128'(rsp_id),     '0);
    check({tag, "_req0_ready"}, 128'(req0_ready), '0);
    check({tag, "_req1_ready"}, 128'(req1_ready), '0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [PLAIN_W-1:0] p0, p1, p2, p3, p4, exp_bitrev;
    logic [KEY_W-1:0]   k0, k1;
    p0 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    p1 = 128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0;
    p2 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    p3 = 128'h8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff;
    p4 = 128'h5a5a_5a5a_a5a5_a5a5_0f0f_0f0f_f0f0_f0f0;
    k0 = 64'h1111_2222_3333_4444;
    k1 = 64'h9999_aaaa_bbbb_cccc;
`ifdef ENC_REQ_SCHED_BITREV_EN
    exp_bitrev = {1'b1, 127'b0};
`else
    exp_bitrev = 128'h1;
`endif

    // Reset state
    #2;
    check_all_zero("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Single request from requester 0
    @(negedge sys_clk);
    req0_valid = 1'b1;
    req0_plain = '1;
    req0_key   = '0;
    #1;
    check("t1_req0_ready", 128'(req0_ready), 128'(1'b1));
    check("t1_req1_ready", 128'(req1_ready), 128'(1'b0));
    @(negedge sys_clk);
    req0_valid = 1'b0;
    #1;
    check("t1_busy", 128'(busy), 128'(1'b1));
    check("t1_core_plain", core_plain, '1);
    check("t1_req0_ready_wait", 128'(req0_ready), 128'(1'b0));
    wait_rsp(n);
    check("t1_latency", 128'(n), 128'(CORE_LAT));
    check("t1_cipher", rsp_cipher, '0);
    check("t1_id", 128'(rsp_id), 128'(1'b0));

    // Back-pressure in DONE with both requesters waiting
    req0_valid = 1'b1; req0_plain = p0; req0_key = k0;
    req1_valid = 1'b1; req1_plain = p1; req1_key = k1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_rsp_valid", 128'(rsp_valid), 128'(1'b1));
      check("bp_cipher", rsp_cipher, '0);
      check("bp_id", 128'(rsp_id), 128'(1'b0));
      check("bp_busy", 128'(busy), 128'(1'b1));
      check("bp_readys", 128'({req1_ready, req0_ready}), 128'(2'b00));
      @(negedge sys_clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_readys", 128'({req1_ready, req0_ready}), 128'(2'b00));
    @(negedge sys_clk);
    rsp_ready = 1'b0;
    #1;
    check("bp_after_valid", 128'(rsp_valid), 128'(1'b0));
    check("bp_after_busy", 128'(busy), 128'(1'b0));
    check("bp_after_rr", 128'({req1_ready, req0_ready}), 128'(2'b10));

    // Contention from reset, response always accepted
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("ct_first_grant", 128'({req1_ready, req0_ready}), 128'(2'b01));
    for (int t = 0; t < 4; t++) begin
      @(negedge sys_clk);
      #1;
      wait_rsp(n);
      check("ct_id", 128'(rsp_id), 128'(t % 2));
      check("ct_cipher", rsp_cipher, (t % 2 == 0) ? ~p0 : ~p1);
      check("ct_core_key", 128'(core_key), (t % 2 == 0) ? 128'(k0) : 128'(k1));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge sys_clk);
    rsp_ready = 1'b0;

    // Requester 1 raises and drops valid while the FSM is in WAIT
    req0_valid = 1'b1; req0_plain = p2;
    #1;
    check("wd_req0_ready", 128'(req0_ready), 128'(1'b1));
    @(negedge sys_clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    #1;
    check("wd_req1_ready_a", 128'(req1_ready), 128'(1'b0));
    @(negedge sys_clk);
    #1;
    check("wd_req1_ready_b", 128'(req1_ready), 128'(1'b0));
    req1_valid = 1'b0;
    wait_rsp(n);
    check("wd_id", 128'(rsp_id), 128'(1'b0));
    check("wd_cipher", rsp_cipher, ~p2);
    rsp_ready = 1'b1;
    @(negedge sys_clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      #1;
      check("wd_no_rsp", 128'({busy, rsp_valid}), 128'(2'b00));
    end

    // Reset while the counter reads 2
    req0_valid = 1'b1; req0_plain = p3; req0_key = k1;
    #1;
    check("rs_lone_req0", 128'(req0_ready), 128'(1'b1));
    @(negedge sys_clk);
    req0_valid = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("rs_mid_wait");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      #1;
      check("rs_no_stale", 128'(rsp_valid), 128'(1'b0));
    end
    req1_valid = 1'b1; req1_plain = p4; req1_key = k0;
    #1;
    check("rs_req1_grant", 128'({req1_ready, req0_ready}), 128'(2'b10));
    @(negedge sys_clk);
    req1_valid = 1'b0;
    wait_rsp(n);
    check("rs_latency", 128'(n), 128'(CORE_LAT));
    check("rs_id", 128'(rsp_id), 128'(1'b1));
    check("rs_cipher", rsp_cipher, ~p4);
    rsp_ready = 1'b1;
    @(negedge sys_clk);
    rsp_ready = 1'b0;

    // Cipher ordering: core returns 128'h1
    req0_valid = 1'b1; req0_plain = ~128'h1;
    @(negedge sys_clk);
    req0_valid = 1'b0;
    wait_rsp(n);
    check("br_latency", 128'(n), 128'(CORE_LAT));
    check("br_cipher", rsp_cipher, exp_bitrev);
    rsp_ready = 1'b1;
    @(negedge sys_clk);
    rsp_ready = 1'b0;
    #1;
    check("br_done", 128'(busy), 128'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
